// File: rtl/vit_chk_pkg.sv
// rtl/vit_chk_pkg.sv - shared FSM state type and FIFO width helper for the Viterbi BER checker
package vit_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2,
        BAD  = 2'd3
    } chk_state_t;

    // Pointer/level width: one extra bit so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vit_chk_fifo.sv
// rtl/vit_chk_fifo.sv - 1-bit synchronous FIFO holding reference bits awaiting comparison
module vit_chk_fifo
    import vit_chk_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     din,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [ptr_w(DEPTH)-1:0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // The caller qualifies push/pop; a push while full is only issued together with a pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/viterbi_ber_checker.sv
// rtl/viterbi_ber_checker.sv - aligns reference and decoded bits, counts bits/errors; VIT_CHK_BURST_EN adds max_burst_o
module viterbi_ber_checker
    import vit_chk_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int SKIP  = 0,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     ref_valid_i,
    input  logic                     ref_bit_i,
    input  logic                     dec_valid_i,
    input  logic                     dec_bit_i,
    output logic [CNT_W-1:0]         bit_cnt_o,
    output logic [CNT_W-1:0]         err_cnt_o,
    output logic                     err_o,
    output logic [1:0]               state_o,
    output logic [ptr_w(DEPTH)-1:0]  level_o,
    output logic                     overflow_o,
`ifdef VIT_CHK_BURST_EN
    output logic [CNT_W-1:0]         max_burst_o,
`endif
    output logic                     underflow_o
);

    chk_state_t  state;
    chk_state_t  state_nxt;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_dout;
    logic        active;
    logic        pop_en;
    logic        push_en;
    logic        run_pop;
    logic        mismatch;
    logic        warm_last;
    logic [31:0] skip_cnt;

    // Emptiness is judged at cycle start, so a same-cycle push never rescues a pop.
    assign active    = (state == WARM) || (state == RUN);
    assign pop_en    = dec_valid_i && active && !fifo_empty && !clear_i;
    assign push_en   = ref_valid_i && (!fifo_full || pop_en) && !clear_i;
    assign run_pop   = (state == RUN) && pop_en;
    assign mismatch  = fifo_dout ^ dec_bit_i;
    assign warm_last = (state == WARM) && pop_en && (skip_cnt == 32'(SKIP - 1));

    vit_chk_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_en),
        .pop   (pop_en),
        .flush (clear_i),
        .din   (ref_bit_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ref_valid_i) state_nxt = (SKIP == 0) ? RUN : WARM;
            WARM:    if (warm_last) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        if (clear_i) state_nxt = IDLE;
    end

    assign state_o = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skip_cnt    <= '0;
            bit_cnt_o   <= '0;
            err_cnt_o   <= '0;
            err_o       <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (clear_i) begin
            skip_cnt    <= '0;
            bit_cnt_o   <= '0;
            err_cnt_o   <= '0;
            err_o       <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (ref_valid_i && fifo_full && !pop_en) overflow_o <= 1'b1;
            if (dec_valid_i && active && fifo_empty) underflow_o <= 1'b1;
            if ((state == WARM) && pop_en) skip_cnt <= skip_cnt + 32'd1;
            if (run_pop) begin
                if (bit_cnt_o != '1) bit_cnt_o <= bit_cnt_o + CNT_W'(1);
                if (mismatch) begin
                    err_o <= 1'b1;
                    if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
                end
            end
        end
    end

`ifdef VIT_CHK_BURST_EN
    logic [CNT_W-1:0] cur_burst;
    logic [CNT_W-1:0] cur_burst_nxt;

    assign cur_burst_nxt = (cur_burst == '1) ? cur_burst : cur_burst + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_burst   <= '0;
            max_burst_o <= '0;
        end else if (clear_i) begin
            cur_burst   <= '0;
            max_burst_o <= '0;
        end else if (run_pop) begin
            if (mismatch) begin
                cur_burst <= cur_burst_nxt;
                if (cur_burst_nxt > max_burst_o) max_burst_o <= cur_burst_nxt;
            end else begin
                cur_burst <= '0;
            end
        end
    end
`endif

endmodule

// File: doc/viterbi_ber_checker.md
Name: viterbi_ber_checker

Overview:
Receive-end checker for the encoder -> noisy channel -> Viterbi decoder loop. It buffers the reference bits fed to the convolutional encoder and aligns them with the decoder's output bit stream. It compares the two streams bit by bit and counts bits and errors. It sits beside the decoder in the tx/rx harness and reports whether injected channel errors were corrected.

Parameters:
DEPTH, 64, reference FIFO depth in bits; must be a power of 2, minimum 4.
SKIP, 0, number of initial decoded bits popped and discarded uncompared (decoder warm-up).
CNT_W, 16, width of the bit and error counters.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
clear_i  input  1  synchronous clear: flush FIFO, zero counters and stickies, go to IDLE
ref_valid_i  input  1  reference bit strobe (same cycle the encoder accepts the bit)
ref_bit_i  input  1  reference data bit
dec_valid_i  input  1  decoder output bit strobe
dec_bit_i  input  1  decoded data bit
bit_cnt_o  output  CNT_W  number of compared bits, saturating
err_cnt_o  output  CNT_W  number of mismatches, saturating
err_o  output  1  one-cycle pulse per mismatch
state_o  output  2  current FSM state
level_o  output  $clog2(DEPTH)+1  FIFO occupancy
overflow_o  output  1  sticky: reference bit dropped, FIFO full
underflow_o  output  1  sticky: decoded bit arrived with FIFO empty

Behaviour:
- Reset (rst low, async): all outputs 0, FIFO empty, state IDLE.
- FIFO pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full = MSBs differ and LSBs equal.
- Push on ref_valid_i when not full.
- ref_valid_i while full: bit dropped, overflow_o set.
- When push and pop coincide while full, both happen and level is unchanged; no overflow.
- Pop happens on dec_valid_i in WARM or RUN when the FIFO is non-empty at cycle start.
- dec_valid_i with the FIFO empty at cycle start: underflow_o set, bit ignored, no counter change. This holds even if a push happens the same cycle; the push still completes.
- FSM states:
  - IDLE (0): go to WARM on the first ref_valid_i; go directly to RUN instead if SKIP=0.
  - WARM (1): each pop is discarded and increments a skip counter; after the SKIP-th pop, go to RUN.
  - RUN (2): each pop compares the popped reference bit with dec_bit_i.
  - Encoding 3 is unused; it recovers to IDLE.
- dec_valid_i in IDLE is ignored; no underflow is flagged.
- Compare latency is 1 cycle; all outputs are registered.
  - The cycle after a RUN pop, bit_cnt_o increments.
  - On mismatch, err_cnt_o increments and err_o pulses high for one cycle.
  - Back-to-back mismatches give err_o high on consecutive cycles.
- Counters saturate at all-ones and never wrap.
- clear_i has priority over every push and pop in the same cycle. The cycle after clear_i: FIFO empty, counters 0, stickies 0, state IDLE, err_o 0.
- Reset asserted mid-operation discards all state immediately.

Optional Feature:
Macro VIT_CHK_BURST_EN.
- Defined:
  - Adds output max_burst_o [CNT_W], which tracks the longest run of consecutive RUN-state mismatches.
  - A correct compare ends the current run.
  - The value saturates; reset and clear_i set it to 0.
  - It updates in the same cycle as err_cnt_o.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package vit_chk_pkg: state enum type (IDLE=2'd0, WARM=2'd1, RUN=2'd2) and function clog2-based width helper localparam.
- Sub-module vit_chk_fifo: 1-bit-wide synchronous FIFO, parameter DEPTH, with push, pop, flush, dout, full, empty and level ports.
- The checker holds the FSM, counters and sticky flags.

Test Plan:
1. Clean loop, SKIP=0: 100 ref bits; decoder echoes them 10 cycles later -> bit_cnt_o=100, err_cnt_o=0, err_o never high, level_o=0 at end.
2. Double-error burst: decoded bits 27 and 28 inverted -> err_cnt_o=2, err_o high on two consecutive cycles, max_burst_o=2 (with VIT_CHK_BURST_EN).
3. Warm-up, SKIP=4: 50 ref bits, first 4 decoded bits random -> bit_cnt_o=46, err_cnt_o=0, state_o passes 0 -> 1 -> 2.
4. Overflow, DEPTH=8: 9 ref pushes with no dec_valid_i -> level_o=8, overflow_o=1 after the 9th push. Then simultaneous push and pop when full -> level_o stays 8.
5. Underflow: dec_valid_i in RUN with FIFO empty -> underflow_o=1, bit_cnt_o unchanged.
6. Saturation and clear, CNT_W=4: 20 mismatches -> err_cnt_o=15. Then clear_i with a simultaneous ref_valid_i -> all counters 0, level_o=0, state_o=0 the next cycle.
